// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment counter:
// segment patterns, the BCD digit type and an elaboration-time binary-to-BCD helper.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam int unsigned MAX_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;

    // Converts a binary value to packed BCD, digit 0 in [3:0]; used only on constants
    function automatic logic [4*MAX_DIGITS-1:0] bin_to_bcd(input int unsigned value);
        int unsigned                 v;
        logic [4*MAX_DIGITS-1:0]     r;
        v = value;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational BCD digit to seven-segment decoder. Codes 10..15 blank the display.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] seg
);

    // Pattern lookup; non-decimal codes are unreachable but decode to all-off
    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_mux_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed seven-segment output.
// Optional build macro SEG7_MUX_BLANK_EN enables leading-zero blanking of digits above 0.
module seg7_mux_counter
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 10_000_000,
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned LIMIT      = 99,
    parameter int unsigned SCAN_DIV   = 10_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    step,
    output logic                    wrap
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [4*MAX_DIGITS-1:0] LIMIT_BCD_ALL = bin_to_bcd(LIMIT);
    localparam logic [4*NUM_DIGITS-1:0] LIMIT_BCD     = LIMIT_BCD_ALL[4*NUM_DIGITS-1:0];

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("seg7_mux_counter: CLK_DIV must be >= 2");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("seg7_mux_counter: SCAN_DIV must be >= 1");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seg7_mux_counter: NUM_DIGITS must be 1..4");
    end
    if (LIMIT < 1 || LIMIT > 10**NUM_DIGITS - 1) begin : g_bad_limit
        $error("seg7_mux_counter: LIMIT out of range for NUM_DIGITS");
    end

    logic [PW-1:0]           presc_q, presc_d;
    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    step_q, step_d;
    logic                    wrap_q, wrap_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    // Ripple carry/borrow chain producing count+1 and count-1 in BCD
    logic [NUM_DIGITS-1:0]   carry, borrow;
    logic [4*NUM_DIGITS-1:0] cnt_inc, cnt_dec;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_t d;
        assign d = count_q[4*i +: 4];
        assign cnt_inc[4*i +: 4] = !carry[i]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        assign cnt_dec[4*i +: 4] = !borrow[i] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
        if (i < NUM_DIGITS - 1) begin : g_chain
            assign carry[i+1]  = carry[i] && (d == 4'd9);
            assign borrow[i+1] = borrow[i] && (d == 4'd0);
        end
    end

    // Prescaler and count update; clear wins over a step due on the same edge
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (en) begin
            if (presc_q == PW'(CLK_DIV - 1)) begin
                presc_d = '0;
                step_d  = 1'b1;
                if (up_dn) begin
                    if (count_q == LIMIT_BCD) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = cnt_inc;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = LIMIT_BCD;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = cnt_dec;
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Free-running scan timer and digit index
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Select the digit currently being scanned
    bcd_digit_t sel_digit;
    logic       blank_sel;
    logic [6:0] dec_seg;

`ifdef SEG7_MUX_BLANK_EN
    // lead_zero[k]: digit k and every digit above it are zero
    logic [NUM_DIGITS-1:0] lead_zero;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        if (k == NUM_DIGITS - 1) begin : g_top
            assign lead_zero[k] = (count_q[4*k +: 4] == 4'd0);
        end else begin : g_mid
            assign lead_zero[k] = (count_q[4*k +: 4] == 4'd0) && lead_zero[k+1];
        end
    end
`endif

    // Mux the scanned digit and its blanking flag
    always_comb begin
        sel_digit = '0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_digit = count_q[4*i +: 4];
`ifdef SEG7_MUX_BLANK_EN
                blank_sel = (i != 0) && lead_zero[i];
`endif
            end
        end
    end

    seg7_hex_decode u_decode (
        .digit (sel_digit),
        .seg   (dec_seg)
    );

    // Output register inputs: seg and an update together from the same index
    always_comb begin
        seg_d = blank_sel ? SEG_OFF : dec_seg;
        an_d  = NUM_DIGITS'(1) << idx_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            count_q    <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            an_q       <= '0;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign count_bcd = count_q;
    assign step      = step_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Self-checking bench for seg7_mux_counter (CLK_DIV=4, NUM_DIGITS=2, LIMIT=12, SCAN_DIV=2).
module tb_seg7_mux_counter;
    import seg7_pkg::*;

`ifdef SEG7_MUX_BLANK_EN
    localparam logic [6:0] D1_ZERO = SEG_OFF;
`else
    localparam logic [6:0] D1_ZERO = SEG_0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [7:0] count_bcd;
    logic       step;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       up;
        logic [7:0] bcd;
        logic       wr;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    seg7_mux_counter #(
        .CLK_DIV    (4),
        .NUM_DIGITS (2),
        .LIMIT      (12),
        .SCAN_DIV   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .clear     (clear),
        .seg       (seg),
        .an        (an),
        .count_bcd (count_bcd),
        .step      (step),
        .wrap      (wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bounded wait for the next step pulse; n = clocks waited, 0 on timeout
    task automatic wait_step(output int n);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                n = i;
                break;
            end
            chk("wrap idle", {31'd0, wrap}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " count"}, {24'd0, count_bcd}, 32'd0);
        chk({tag, " seg"},   {25'd0, seg},       32'd0);
        chk({tag, " an"},    {30'd0, an},        32'd0);
        chk({tag, " step"},  {31'd0, step},      32'd0);
        chk({tag, " wrap"},  {31'd0, wrap},      32'd0);
    endtask

    // Sync to an an-transition, then expect 2-clock alternation with matching seg
    task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1, input string tag);
        logic [1:0] a0;
        logic [1:0] e;
        int         found;
        found = 0;
        a0    = an;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (an !== a0) begin
                found = 1;
                break;
            end
        end
        chk({tag, " an toggles"}, found, 32'd1);
        a0 = an;
        chk({tag, " an onehot"}, {31'd0, (a0 == 2'b01 || a0 == 2'b10)}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            e = ((i / 2) % 2 == 0) ? a0 : {a0[0], a0[1]};
            chk({tag, " an"},  {30'd0, an},  {30'd0, e});
            chk({tag, " seg"}, {25'd0, seg}, {25'd0, (e == 2'b01) ? s0 : s1});
        end
    endtask

    initial begin
        int n;

        for (int i = 0; i < 9; i++) vecs[i] = '{1'b1, 8'(i + 1), 1'b0};
        vecs[9]  = '{1'b1, 8'h10, 1'b0};
        vecs[10] = '{1'b1, 8'h11, 1'b0};
        vecs[11] = '{1'b1, 8'h12, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 8'h12, 1'b1};
        vecs[14] = '{1'b0, 8'h11, 1'b0};
        vecs[15] = '{1'b0, 8'h10, 1'b0};
        vecs[16] = '{1'b0, 8'h09, 1'b0};

        // Power-on reset
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("an after reset onehot", {31'd0, (an == 2'b01 || an == 2'b10)}, 32'd1);

        // Up to LIMIT, wrap, then down through the borrow
        en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            up_dn = vecs[i].up;
            wait_step(n);
            chk($sformatf("vec%0d interval", i), n, 32'd4);
            chk($sformatf("vec%0d count", i), {24'd0, count_bcd}, {24'd0, vecs[i].bcd});
            chk($sformatf("vec%0d wrap", i), {31'd0, wrap}, {31'd0, vecs[i].wr});
        end

        // Enable low: nothing moves
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold step", {31'd0, step}, 32'd0);
        end
        chk("hold count", {24'd0, count_bcd}, 32'h09);

        // Clear on the cycle a step is due
        en    = 1'b1;
        up_dn = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        chk("clear count", {24'd0, count_bcd}, 32'h00);
        chk("clear step", {31'd0, step}, 32'd0);
        clear = 1'b0;
        wait_step(n);
        chk("post-clear interval", n, 32'd4);
        chk("post-clear count", {24'd0, count_bcd}, 32'h01);

        // Reach 12 and check scanning
        for (int i = 0; i < 11; i++) wait_step(n);
        en = 1'b0;
        chk("scan count", {24'd0, count_bcd}, 32'h12);
        scan_check(SEG_2, SEG_1, "scan12");

        // Leading-zero handling at 00 and 05
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("zero count", {24'd0, count_bcd}, 32'h00);
        scan_check(SEG_0, D1_ZERO, "scan00");
        en = 1'b1;
        for (int i = 0; i < 5; i++) wait_step(n);
        en = 1'b0;
        chk("five count", {24'd0, count_bcd}, 32'h05);
        scan_check(SEG_5, D1_ZERO, "scan05");

        // Asynchronous reset mid-count at 07
        en = 1'b1;
        for (int i = 0; i < 2; i++) wait_step(n);
        en = 1'b0;
        chk("pre-reset count", {24'd0, count_bcd}, 32'h07);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
